// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries decoded control through ID/EX, EX/MEM and MEM/WB, resolves branch/jump in EX, counts retirements.
// Latency: decode fields reach EX outputs after 1 edge, MEM after 2, WB after 3; PCSrcE is combinational in EX.
// Backpressure: none; EX/MEM and MEM/WB load every cycle, and ID/EX takes a bubble on FlushE.
module ctrl_pipe #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             ALUSrcD,
  input  logic [1:0]       JumpD,
  input  logic [1:0]       ResultSrcD,
  input  logic [2:0]       BranchD,
  input  logic [2:0]       AluControlD,
  input  logic [4:0]       RdD,
  input  logic             ValidD,
  input  logic             FlushE,
  input  logic             ZeroE,
  input  logic             LtE,
  output logic             ALUSrcE,
  output logic [2:0]       AluControlE,
  output logic [1:0]       ResultSrcE,
  output logic [4:0]       RdE,
  output logic             RegWriteE,
  output logic [1:0]       PCSrcE,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic [1:0]       ResultSrcM,
  output logic [4:0]       RdM,
  output logic             RegWriteW,
  output logic [1:0]       ResultSrcW,
  output logic [4:0]       RdW,
  output logic [CNT_W-1:0] RetiredCnt
);

  // Fields common to every stage register.
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic [4:0] rd;
  } stage_t;

  // ID/EX additionally carries the execute-only controls.
  typedef struct packed {
    stage_t     s;
    logic       alu_src;
    logic [2:0] alu_ctrl;
    logic [2:0] branch;
    logic [1:0] jump;
  } ex_t;

  ex_t             ex_q, ex_d;
  stage_t          mem_q, mem_d;
  stage_t          wb_q, wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            taken;

  // Next-state for all stages: capture decode (or a bubble on flush), shift the rest.
  always_comb begin
    ex_d = '0;
    if (!FlushE) begin
      ex_d.s.valid      = ValidD;
      // Writes to x0 are architecturally discarded, so drop them at capture.
      ex_d.s.reg_write  = RegWriteD & (RdD != 5'd0);
      ex_d.s.mem_write  = MemWriteD;
      ex_d.s.result_src = ResultSrcD;
      ex_d.s.rd         = RdD;
      ex_d.alu_src      = ALUSrcD;
      ex_d.alu_ctrl     = AluControlD;
      ex_d.branch       = BranchD;
      ex_d.jump         = JumpD;
    end
    mem_d = ex_q.s;
    wb_d  = mem_q;
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, wb_q.valid};
  end

  // Stage registers and retire counter; synchronous reset wins over flush.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  // Branch/jump resolution for the instruction currently in EX.
  always_comb begin
    taken  = 1'b0;
    PCSrcE = 2'b00;
    case (ex_q.branch)
      3'b001:  taken = ZeroE;
      3'b010:  taken = ~ZeroE;
      3'b011:  taken = LtE;
      3'b100:  taken = ~LtE;
      default: taken = 1'b0;
    endcase
    if (ex_q.s.valid) begin
      if (ex_q.jump == 2'b10) begin
        PCSrcE = 2'b10;
      end else if (ex_q.jump == 2'b01 || taken) begin
        PCSrcE = 2'b01;
      end
    end
  end

  assign ALUSrcE     = ex_q.alu_src;
  assign AluControlE = ex_q.alu_ctrl;
  assign ResultSrcE  = ex_q.s.result_src;
  assign RdE         = ex_q.s.rd;
  assign RegWriteE   = ex_q.s.reg_write;
  assign RegWriteM   = mem_q.reg_write;
  assign MemWriteM   = mem_q.mem_write;
  assign ResultSrcM  = mem_q.result_src;
  assign RdM         = mem_q.rd;
  assign RegWriteW   = wb_q.reg_write;
  assign ResultSrcW  = wb_q.result_src;
  assign RdW         = wb_q.rd;
  assign RetiredCnt  = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: branch vector table, hand sequences for flow/flush/wrap, then random traffic
// checked against an instruction-history model. Two instances: default counter width and CNT_W=4.
module tb_ctrl_pipe;

  logic clk;
  logic rst;
  logic RegWriteD, MemWriteD, ALUSrcD, ValidD, FlushE, ZeroE, LtE;
  logic [1:0] JumpD, ResultSrcD;
  logic [2:0] BranchD, AluControlD;
  logic [4:0] RdD;

  logic ALUSrcE, RegWriteE, RegWriteM, MemWriteM, RegWriteW;
  logic [2:0] AluControlE;
  logic [1:0] ResultSrcE, PCSrcE, ResultSrcM, ResultSrcW;
  logic [4:0] RdE, RdM, RdW;
  logic [31:0] RetiredCnt;

  logic ALUSrcE4, RegWriteE4, RegWriteM4, MemWriteM4, RegWriteW4;
  logic [2:0] AluControlE4;
  logic [1:0] ResultSrcE4, PCSrcE4, ResultSrcM4, ResultSrcW4;
  logic [4:0] RdE4, RdM4, RdW4;
  logic [3:0] RetiredCnt4;

  ctrl_pipe dut (
    .clk(clk), .rst(rst), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD),
    .JumpD(JumpD), .ResultSrcD(ResultSrcD), .BranchD(BranchD), .AluControlD(AluControlD),
    .RdD(RdD), .ValidD(ValidD), .FlushE(FlushE), .ZeroE(ZeroE), .LtE(LtE),
    .ALUSrcE(ALUSrcE), .AluControlE(AluControlE), .ResultSrcE(ResultSrcE), .RdE(RdE),
    .RegWriteE(RegWriteE), .PCSrcE(PCSrcE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .RdM(RdM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .RdW(RdW), .RetiredCnt(RetiredCnt)
  );

  ctrl_pipe #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD),
    .JumpD(JumpD), .ResultSrcD(ResultSrcD), .BranchD(BranchD), .AluControlD(AluControlD),
    .RdD(RdD), .ValidD(ValidD), .FlushE(FlushE), .ZeroE(ZeroE), .LtE(LtE),
    .ALUSrcE(ALUSrcE4), .AluControlE(AluControlE4), .ResultSrcE(ResultSrcE4), .RdE(RdE4),
    .RegWriteE(RegWriteE4), .PCSrcE(PCSrcE4), .RegWriteM(RegWriteM4), .MemWriteM(MemWriteM4),
    .ResultSrcM(ResultSrcM4), .RdM(RdM4), .RegWriteW(RegWriteW4), .ResultSrcW(ResultSrcW4),
    .RdW(RdW4), .RetiredCnt(RetiredCnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // One decoded instruction as the model sees it after capture.
  typedef struct packed {
    logic       v;
    logic       rw;
    logic       mw;
    logic [1:0] rs;
    logic [4:0] rd;
    logic       as;
    logic [2:0] ac;
    logic [2:0] br;
    logic [1:0] jp;
  } instr_t;

  // Model: the last three captured instructions (index 0 = EX, 1 = MEM, 2 = WB) and a retire tally.
  instr_t hist[3];
  longint retired;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_pcsrc(input instr_t e, input logic z, input logic lt);
    logic tk;
    tk = (e.br == 3'd1 && z) || (e.br == 3'd2 && !z) || (e.br == 3'd3 && lt) || (e.br == 3'd4 && !lt);
    if (!e.v)            return 2'b00;
    if (e.jp == 2'b10)   return 2'b10;
    if (e.jp == 2'b01 || tk) return 2'b01;
    return 2'b00;
  endfunction

  // Advance one clock; the model records what the decode inputs looked like at the edge.
  task automatic cyc();
    instr_t n;
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 3; i++) hist[i] = '0;
      retired = 0;
    end else begin
      if (hist[2].v) retired++;
      n = '0;
      if (!FlushE) begin
        n = '{ValidD, RegWriteD && RdD != 0, MemWriteD, ResultSrcD, RdD, ALUSrcD, AluControlD, BranchD, JumpD};
      end
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = n;
    end
    #1;
  endtask

  task automatic check_all();
    logic [31:0] exp4, got4;
    chk("ALUSrcE", ALUSrcE, hist[0].as);
    chk("AluControlE", AluControlE, hist[0].ac);
    chk("ResultSrcE", ResultSrcE, hist[0].rs);
    chk("RdE", RdE, hist[0].rd);
    chk("RegWriteE", RegWriteE, hist[0].rw);
    chk("PCSrcE", PCSrcE, exp_pcsrc(hist[0], ZeroE, LtE));
    chk("RegWriteM", RegWriteM, hist[1].rw);
    chk("MemWriteM", MemWriteM, hist[1].mw);
    chk("ResultSrcM", ResultSrcM, hist[1].rs);
    chk("RdM", RdM, hist[1].rd);
    chk("RegWriteW", RegWriteW, hist[2].rw);
    chk("ResultSrcW", ResultSrcW, hist[2].rs);
    chk("RdW", RdW, hist[2].rd);
    chk("RetiredCnt", RetiredCnt, retired[31:0]);
    exp4 = {hist[0].as, hist[0].ac, hist[0].rs, hist[0].rd, hist[0].rw, exp_pcsrc(hist[0], ZeroE, LtE),
            hist[1].rw, hist[1].mw, hist[1].rs, hist[1].rd, hist[2].rw, hist[2].rs, hist[2].rd};
    got4 = {ALUSrcE4, AluControlE4, ResultSrcE4, RdE4, RegWriteE4, PCSrcE4,
            RegWriteM4, MemWriteM4, ResultSrcM4, RdM4, RegWriteW4, ResultSrcW4, RdW4};
    chk("dut4_stages", got4, exp4);
    chk("RetiredCnt4", RetiredCnt4, retired[3:0]);
  endtask

  task automatic set_instr(input logic v, input logic rw, input logic mw, input logic [1:0] rs,
                           input logic [4:0] rd, input logic [2:0] br, input logic [1:0] jp);
    ValidD = v; RegWriteD = rw; MemWriteD = mw; ResultSrcD = rs; RdD = rd;
    BranchD = br; JumpD = jp; ALUSrcD = 1'b0; AluControlD = 3'd0;
  endtask

  task automatic rand_inputs();
    RegWriteD = 1'($urandom); MemWriteD = 1'($urandom); ALUSrcD = 1'($urandom);
    JumpD = 2'($urandom); ResultSrcD = 2'($urandom); BranchD = 3'($urandom);
    AluControlD = 3'($urandom); RdD = 5'($urandom); ValidD = 1'($urandom);
    ZeroE = 1'($urandom); LtE = 1'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b0; FlushE = 1'b0;
    cyc();
    rst = 1'b1;
  endtask

  typedef struct {
    logic       v;
    logic [2:0] br;
    logic [1:0] jp;
    logic       z;
    logic       lt;
    logic       fl;
    logic [1:0] exp;
  } vec_t;

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{1'b1, 3'b001, 2'b00, 1'b1, 1'b0, 1'b0, 2'b01}; // beq taken
    tbl[1]  = '{1'b1, 3'b001, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00}; // beq not taken
    tbl[2]  = '{1'b1, 3'b010, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01}; // bne taken
    tbl[3]  = '{1'b1, 3'b010, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00}; // bne not taken
    tbl[4]  = '{1'b1, 3'b011, 2'b00, 1'b0, 1'b1, 1'b0, 2'b01}; // blt taken
    tbl[5]  = '{1'b1, 3'b011, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00}; // blt not taken
    tbl[6]  = '{1'b1, 3'b100, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00}; // bge not taken
    tbl[7]  = '{1'b1, 3'b100, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01}; // bge taken
    tbl[8]  = '{1'b1, 3'b111, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00}; // reserved branch code
    tbl[9]  = '{1'b1, 3'b101, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00}; // reserved branch code
    tbl[10] = '{1'b1, 3'b001, 2'b10, 1'b1, 1'b0, 1'b0, 2'b10}; // jalr beats branch
    tbl[11] = '{1'b1, 3'b000, 2'b01, 1'b0, 1'b0, 1'b0, 2'b01}; // jal
    tbl[12] = '{1'b1, 3'b000, 2'b11, 1'b1, 1'b1, 1'b0, 2'b00}; // jump code 11 ignored
    tbl[13] = '{1'b1, 3'b000, 2'b01, 1'b0, 1'b0, 1'b1, 2'b00}; // jal flushed
    tbl[14] = '{1'b1, 3'b000, 2'b10, 1'b0, 1'b0, 1'b1, 2'b00}; // jalr flushed
    tbl[15] = '{1'b0, 3'b001, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00}; // invalid slot

    for (int i = 0; i < 3; i++) hist[i] = '0;
    retired = 0;
    rst = 1'b0; FlushE = 1'b0;
    rand_inputs();

    // Reset held for two cycles with random decode inputs: every output reads zero.
    for (int i = 0; i < 2; i++) begin
      rand_inputs();
      cyc();
    end
    ZeroE = 1'b1; LtE = 1'b0;
    #1;
    chk("rst_outputs", {ALUSrcE, AluControlE, ResultSrcE, RdE, RegWriteE, PCSrcE, RegWriteM, MemWriteM,
                        ResultSrcM, RdM, RegWriteW, ResultSrcW, RdW}, 64'd0);
    chk("rst_cnt", RetiredCnt, 64'd0);
    check_all();

    // First instruction after release shows up in EX one edge later.
    rst = 1'b1;
    set_instr(1'b1, 1'b1, 1'b0, 2'b11, 5'd9, 3'b000, 2'b01);
    cyc();
    chk("first_RdE", RdE, 64'd9);
    chk("first_PCSrcE", PCSrcE, 64'd1);
    check_all();

    // Pipeline flow: addi x5, lw x6, sw.
    do_reset();
    set_instr(1'b1, 1'b1, 1'b0, 2'b00, 5'd5, 3'b000, 2'b00); cyc();
    set_instr(1'b1, 1'b1, 1'b0, 2'b01, 5'd6, 3'b000, 2'b00); cyc();
    set_instr(1'b1, 1'b0, 1'b1, 2'b10, 5'd0, 3'b000, 2'b00); cyc();
    chk("flow_RdW_addi", {RegWriteW, RdW}, {1'b1, 5'd5});
    set_instr(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 3'b000, 2'b00); cyc();
    chk("flow_RdW_lw", {ResultSrcW, RdW}, {2'b01, 5'd6});
    chk("flow_sw_M", {MemWriteM, RegWriteM}, 2'b10);
    cyc();
    chk("flow_sw_W", ResultSrcW, 64'd2);
    cyc();
    chk("flow_cnt", RetiredCnt, 64'd3);
    check_all();

    // x0 destination suppresses the write; a flushed store never reaches MEM or retires.
    do_reset();
    set_instr(1'b1, 1'b1, 1'b0, 2'b00, 5'd0, 3'b000, 2'b00); cyc();
    chk("x0_RegWriteE", RegWriteE, 64'd0);
    set_instr(1'b1, 1'b1, 1'b0, 2'b00, 5'd7, 3'b000, 2'b00); cyc();
    set_instr(1'b1, 1'b0, 1'b1, 2'b10, 5'd0, 3'b000, 2'b00); FlushE = 1'b1; cyc();
    chk("flush_ex_advances_RdM", RdM, 64'd7);
    FlushE = 1'b1; cyc(); // back-to-back bubble
    FlushE = 1'b0;
    set_instr(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 3'b000, 2'b00); cyc();
    chk("flush_sw_MemWriteM", MemWriteM, 64'd0);
    cyc(); cyc(); cyc();
    chk("flush_cnt", RetiredCnt, 64'd2);
    check_all();

    // Branch and jump resolution table.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_instr(tbl[i].v, 1'b0, 1'b0, 2'b00, 5'd1, tbl[i].br, tbl[i].jp);
      FlushE = tbl[i].fl;
      cyc();
      ZeroE = tbl[i].z; LtE = tbl[i].lt;
      #1;
      chk($sformatf("pcsrc_vec%0d", i), PCSrcE, tbl[i].exp);
    end
    FlushE = 1'b0;

    // Counter wrap on the 4-bit instance: 17 valid instructions.
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      set_instr(k <= 17, 1'b0, 1'b0, 2'b00, 5'd3, 3'b000, 2'b00);
      cyc();
      if (k == 18) chk("wrap_15", RetiredCnt4, 64'd15);
      if (k == 19) chk("wrap_0", RetiredCnt4, 64'd0);
      if (k == 20) chk("wrap_1", RetiredCnt4, 64'd1);
    end
    chk("wrap_cnt32", RetiredCnt, 64'd17);

    // Random traffic, occasional flush and reset, checked every cycle.
    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      FlushE = ($urandom_range(0, 3) == 0);
      rst    = ($urandom_range(0, 49) != 0);
      #1;
      check_all();
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
